// File: rtl/pong_pkg.sv
// Shared definitions for the pong playfield blocks: collision event codes,
// ball controller state enumeration, playfield defaults and paddle geometry
// used by the collision detector, paddle logic and ball motion controller.
package pong_pkg;

  localparam int FIELD_W_DEF = 64;
  localparam int FIELD_H_DEF = 64;

  // Paddle geometry shared with the collision detector and paddle logic.
  localparam int PADDLE_L_X = 2;
  localparam int PADDLE_R_X = 61;
  localparam int PADDLE_H   = 6;

  // Collision event codes carried on coll_type; 5-7 are reserved.
  localparam logic [2:0] COLL_NONE    = 3'd0;
  localparam logic [2:0] COLL_WALL    = 3'd1;
  localparam logic [2:0] COLL_PADDLE  = 3'd2;
  localparam logic [2:0] COLL_GOAL_P1 = 3'd3;
  localparam logic [2:0] COLL_GOAL_P2 = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_MOVE  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

endpackage

// File: rtl/ball_step_timer.sv
// Frame-tick timing for the ball controller.
//   - Serve countdown: load reloads it with SERVE_DELAY, each frame_tick
//     decrements it; serve_done flags the tick that ends the serve hold
//     (counter at 1, or already 0 when SERVE_DELAY is 0).
//   - Step divider: counts frame ticks, step_pulse flags every SPEED_DIV-th
//     tick; clr holds it at zero.
// Ports: clk, rst (sync active-high), load, clr, frame_tick in;
//        step_pulse, serve_done out (combinational, qualified by frame_tick).
module ball_step_timer #(
  parameter int SERVE_DELAY = 60,
  parameter int SPEED_DIV   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clr,
  input  logic frame_tick,
  output logic step_pulse,
  output logic serve_done
);

  localparam int SC_W  = (SERVE_DELAY < 1) ? 1 : $clog2(SERVE_DELAY + 1);
  localparam int DIV_W = (SPEED_DIV < 2) ? 1 : $clog2(SPEED_DIV);

  localparam logic [SC_W-1:0]  SC_LOAD  = SC_W'(SERVE_DELAY);
  localparam logic [SC_W-1:0]  SC_ONE   = SC_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPEED_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [SC_W-1:0]  serve_cnt;
  logic [DIV_W-1:0] div_cnt;

  assign serve_done = frame_tick && (serve_cnt <= SC_ONE);
  assign step_pulse = frame_tick && (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      serve_cnt <= '0;
      div_cnt   <= '0;
    end else begin
      if (load)
        serve_cnt <= SC_LOAD;
      else if (frame_tick && (serve_cnt != '0))
        serve_cnt <= serve_cnt - SC_ONE;

      if (clr)
        div_cnt <= '0;
      else if (frame_tick)
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_ONE;
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball motion controller for the 64x64 pong playfield.
// Owns ball position/direction, both scores and the serve / game-over
// sequencing. Consumes one collision event per coll_valid/coll_ack handshake
// and steps the ball once every SPEED_DIV frame ticks while in MOVE.
// Ports:
//   clk, rst (sync active-high), frame_tick, start     control inputs
//   coll_valid, coll_type[2:0] / coll_ack               event handshake
//   bx, by, dir_x, dir_y                                ball state
//   sc1, sc2                                            player scores
//   ball_active (MOVE), game_over (OVER), winner        status
module ball_motion_ctrl
  import pong_pkg::*;
#(
  parameter int FIELD_W     = FIELD_W_DEF,
  parameter int FIELD_H     = FIELD_H_DEF,
  parameter int COORD_W     = 6,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 60,
  parameter int SPEED_DIV   = 2,
  parameter int START_X     = 31,
  parameter int START_Y     = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               coll_valid,
  input  logic [2:0]         coll_type,
  output logic               coll_ack,
  output logic [COORD_W-1:0] bx,
  output logic [COORD_W-1:0] by,
  output logic               dir_x,
  output logic               dir_y,
  output logic [SCORE_W-1:0] sc1,
  output logic [SCORE_W-1:0] sc2,
  output logic               ball_active,
  output logic               game_over,
  output logic               winner
);

  localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(FIELD_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(FIELD_H - 1);
  localparam logic [COORD_W-1:0] X_START = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] Y_START = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] C_ONE   = COORD_W'(1);
  localparam logic [SCORE_W-1:0] S_WIN   = SCORE_W'(WIN_SCORE);

  // Score increment that sticks at all-ones.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + SCORE_W'(1);
  endfunction

  // One-pixel x step clamped to the playfield edges (no reflection).
  function automatic logic [COORD_W-1:0] x_step(input logic [COORD_W-1:0] x,
                                                input logic right);
    if (right)
      return (x == X_MAX) ? x : x + C_ONE;
    else
      return (x == '0) ? x : x - C_ONE;
  endfunction

  state_t state, state_d;

  logic [COORD_W-1:0] bx_d, by_d;
  logic               dx_d, dy_d;
  logic [SCORE_W-1:0] sc1_d, sc2_d;
  logic               winner_d;
  logic               ack_fire;
  logic               goal;
  logic               load;
  logic               clr;
  logic               step_pulse;
  logic               serve_done;

  // The ack register itself blocks a second ack on the following cycle.
  assign ack_fire = coll_valid && !coll_ack;

  // Divider runs only in MOVE, so it is zero on every entry to MOVE.
  assign clr = (state != ST_MOVE);

  ball_step_timer #(
    .SERVE_DELAY (SERVE_DELAY),
    .SPEED_DIV   (SPEED_DIV)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .clr        (clr),
    .frame_tick (frame_tick),
    .step_pulse (step_pulse),
    .serve_done (serve_done)
  );

  always_comb begin
    state_d  = state;
    bx_d     = bx;
    by_d     = by;
    dx_d     = dir_x;
    dy_d     = dir_y;
    sc1_d    = sc1;
    sc2_d    = sc2;
    winner_d = winner;
    load     = 1'b0;
    goal     = 1'b0;

    if (start) begin
      state_d = ST_SERVE;
      sc1_d   = '0;
      sc2_d   = '0;
      bx_d    = X_START;
      by_d    = Y_START;
      load    = 1'b1;
    end else begin
      case (state)
        ST_SERVE: begin
          if (serve_done)
            state_d = ST_MOVE;
        end
        ST_MOVE: begin
          // Events outside MOVE are acked but have no effect.
          if (ack_fire) begin
            case (coll_type)
              COLL_WALL:   dy_d = ~dir_y;
              COLL_PADDLE: dx_d = ~dir_x;
              COLL_GOAL_P1: begin
                goal     = 1'b1;
                sc1_d    = sat_inc(sc1);
                dx_d     = 1'b1;
                winner_d = 1'b0;
              end
              COLL_GOAL_P2: begin
                goal     = 1'b1;
                sc2_d    = sat_inc(sc2);
                dx_d     = 1'b0;
                winner_d = 1'b1;
              end
              default: ;
            endcase
          end

          if (goal) begin
            if ((coll_type == COLL_GOAL_P1) ? (sc1_d == S_WIN) : (sc2_d == S_WIN)) begin
              state_d = ST_OVER;
            end else begin
              state_d  = ST_SERVE;
              winner_d = winner;
              bx_d     = X_START;
              by_d     = Y_START;
              load     = 1'b1;
            end
          end else if (step_pulse) begin
            // Step uses the post-event direction; y reflects at the edges
            // instead of moving past them.
            bx_d = x_step(bx, dx_d);
            if (dy_d) begin
              if (by == Y_MAX) dy_d = 1'b0;
              else             by_d = by + C_ONE;
            end else begin
              if (by == '0)    dy_d = 1'b1;
              else             by_d = by - C_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      bx       <= X_START;
      by       <= Y_START;
      dir_x    <= 1'b1;
      dir_y    <= 1'b1;
      sc1      <= '0;
      sc2      <= '0;
      winner   <= 1'b0;
      coll_ack <= 1'b0;
    end else begin
      state    <= state_d;
      bx       <= bx_d;
      by       <= by_d;
      dir_x    <= dx_d;
      dir_y    <= dy_d;
      sc1      <= sc1_d;
      sc2      <= sc2_d;
      winner   <= winner_d;
      coll_ack <= ack_fire;
    end
  end

  assign ball_active = (state == ST_MOVE);
  assign game_over   = (state == ST_OVER);

endmodule
